// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the host-to-APB bridge.
// Address map: [27:24] peripheral select, [23:0] APB offset.
package apb_bridge_pkg;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STRB_W     = DATA_W / 8;
    localparam int NUM_PERIPH = 16;
    localparam int PADDR_W    = 24;
    localparam int SEL_LSB    = 24;
    localparam int SEL_W      = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } state_t;

    typedef struct packed {
        logic [SEL_W-1:0]   sel;
        logic [PADDR_W-1:0] paddr;
        logic               pwrite;
        logic [STRB_W-1:0]  pstrb;
        logic [DATA_W-1:0]  pwdata;
    } apb_req_t;

endpackage

// File: rtl/apb_bridge_decode.sv
// Peripheral select decode and return-path mux for the APB bridge.
// One-hot is built from the incoming address; the mux uses the latched select.
import apb_bridge_pkg::*;

module apb_bridge_decode (
    input  logic [SEL_W-1:0]                   req_sel,
    input  logic [SEL_W-1:0]                   cur_sel,
    input  logic [NUM_PERIPH-1:0][DATA_W-1:0]  prdata,
    input  logic [NUM_PERIPH-1:0]              pready,
    output logic [NUM_PERIPH-1:0]              req_onehot,
    output logic [DATA_W-1:0]                  sel_prdata,
    output logic                               sel_pready
);

    always_comb begin
        req_onehot          = '0;
        req_onehot[req_sel] = 1'b1;
    end

    assign sel_prdata = prdata[cur_sel];
    assign sel_pready = pready[cur_sel];

endmodule

// File: rtl/apb_bridge_top.sv
// Host valid/ready to 16-port APB master bridge.
// One APB transfer per host request; all outputs come straight from flops.
import apb_bridge_pkg::*;

module apb_bridge_top (
    input  logic                               sys_clk,
    input  logic                               rst,
    input  logic                               host_valid,
    output logic                               host_ready,
    input  logic [ADDR_W-1:0]                  host_addr,
    input  logic [DATA_W-1:0]                  host_wdata,
    input  logic [STRB_W-1:0]                  host_wstrb,
    output logic [DATA_W-1:0]                  host_rdata,
    output logic [NUM_PERIPH-1:0][PADDR_W-1:0] apb_paddr,
    output logic [NUM_PERIPH-1:0]              apb_pwrite,
    output logic [NUM_PERIPH-1:0]              apb_psel,
    output logic [NUM_PERIPH-1:0]              apb_penable,
    output logic [NUM_PERIPH-1:0][STRB_W-1:0]  apb_pstrb,
    output logic [NUM_PERIPH-1:0][DATA_W-1:0]  apb_pwdata,
    input  logic [NUM_PERIPH-1:0][DATA_W-1:0]  apb_prdata,
    input  logic [NUM_PERIPH-1:0]              apb_pready,
    input  logic [NUM_PERIPH-1:0]              apb_pslverr
);

    state_t                  state_q, state_d;
    apb_req_t                req_q, req_d;
    logic [NUM_PERIPH-1:0]   psel_q, psel_d;
    logic [NUM_PERIPH-1:0]   penable_q, penable_d;
    logic                    ready_q, ready_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d;

    logic [NUM_PERIPH-1:0]   req_onehot;
    logic [DATA_W-1:0]       sel_prdata;
    logic                    sel_pready;

    // Slave errors are not reported to the host; top address bits alias.
    logic unused_inputs;
    assign unused_inputs = ^{apb_pslverr, host_addr[ADDR_W-1:SEL_LSB+SEL_W]};

    apb_bridge_decode u_decode (
        .req_sel    (host_addr[SEL_LSB +: SEL_W]),
        .cur_sel    (req_q.sel),
        .prdata     (apb_prdata),
        .pready     (apb_pready),
        .req_onehot (req_onehot),
        .sel_prdata (sel_prdata),
        .sel_pready (sel_pready)
    );

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            req_q     <= '0;
            psel_q    <= '0;
            penable_q <= '0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        ready_d   = 1'b0;
        rdata_d   = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (host_valid) begin
                    req_d.sel    = host_addr[SEL_LSB +: SEL_W];
                    req_d.paddr  = host_addr[PADDR_W-1:0];
                    req_d.pwrite = |host_wstrb;
                    req_d.pstrb  = host_wstrb;
                    req_d.pwdata = host_wdata;
                    psel_d       = req_onehot;
                    state_d      = SETUP;
                end
            end
            SETUP: begin
                penable_d = psel_q;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (sel_pready) begin
                    psel_d    = '0;
                    penable_d = '0;
                    ready_d   = 1'b1;
                    rdata_d   = req_q.pwrite ? '0 : sel_prdata;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign host_ready  = ready_q;
    assign host_rdata  = rdata_q;
    assign apb_psel    = psel_q;
    assign apb_penable = penable_q;

    // Address/data are broadcast; only PSEL distinguishes the target.
    always_comb begin
        for (int p = 0; p < NUM_PERIPH; p++) begin
            apb_paddr[p]  = req_q.paddr;
            apb_pwrite[p] = req_q.pwrite;
            apb_pstrb[p]  = req_q.pstrb;
            apb_pwdata[p] = req_q.pwdata;
        end
    end

endmodule

// File: tb/tb_apb_bridge_top.sv
// Scoreboard bench for apb_bridge_top with simple APB slave models.
// Expected bus and host responses are queued at issue and popped by monitors.
module tb_apb_bridge_top;

    localparam int NP = 16;

    logic                  sys_clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  host_valid = 1'b0;
    logic                  host_ready;
    logic [31:0]           host_addr = '0;
    logic [31:0]           host_wdata = '0;
    logic [3:0]            host_wstrb = '0;
    logic [31:0]           host_rdata;
    logic [NP-1:0][23:0]   apb_paddr;
    logic [NP-1:0]         apb_pwrite;
    logic [NP-1:0]         apb_psel;
    logic [NP-1:0]         apb_penable;
    logic [NP-1:0][3:0]    apb_pstrb;
    logic [NP-1:0][31:0]   apb_pwdata;
    logic [NP-1:0][31:0]   apb_prdata;
    logic [NP-1:0]         apb_pready;
    logic [NP-1:0]         apb_pslverr;

    int checks = 0;
    int failures = 0;
    int wait_cfg = 0;
    logic err_cfg = 1'b0;
    int wcnt;

    typedef struct {
        int          port;
        logic [23:0] paddr;
        logic        pwrite;
        logic [3:0]  pstrb;
        logic [31:0] pwdata;
    } apb_exp_t;

    apb_exp_t    apb_q[$];
    logic [31:0] host_q[$];

    apb_bridge_top dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .host_valid  (host_valid),
        .host_ready  (host_ready),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_wstrb  (host_wstrb),
        .host_rdata  (host_rdata),
        .apb_paddr   (apb_paddr),
        .apb_pwrite  (apb_pwrite),
        .apb_psel    (apb_psel),
        .apb_penable (apb_penable),
        .apb_pstrb   (apb_pstrb),
        .apb_pwdata  (apb_pwdata),
        .apb_prdata  (apb_prdata),
        .apb_pready  (apb_pready),
        .apb_pslverr (apb_pslverr)
    );

    initial forever #5 sys_clk = ~sys_clk;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Each slave answers with a port-specific tag above the offset it sees.
    function automatic logic [7:0] tag(input int p);
        if (p == 0) return 8'hA0;
        if (p == 15) return 8'hF0;
        return 8'hB0 + 8'(p - 1);
    endfunction

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) wcnt <= 0;
        else if (|(apb_psel & apb_penable)) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    always_comb begin
        for (int i = 0; i < NP; i++) begin
            apb_prdata[i]  = {tag(i), apb_paddr[i]};
            apb_pready[i]  = apb_psel[i] ? (wcnt >= wait_cfg) : 1'b1;
            apb_pslverr[i] = apb_psel[i] ? err_cfg : ~err_cfg;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // APB monitor: every SETUP must match the next queued transfer;
    // ACCESS must keep the same selection and payload.
    initial begin : apb_mon
        apb_exp_t cur;
        bit have_cur = 0;
        forever begin
            @(negedge sys_clk);
            if (rst) begin
                have_cur = 0;
            end else begin
                if (apb_psel != 0 || apb_penable != 0)
                    chk("psel_onehot",
                        64'({$onehot(apb_psel), |(apb_penable & ~apb_psel)}),
                        64'(2'b10));
                if (apb_psel != 0 && apb_penable == 0) begin
                    if (apb_q.size() == 0) begin
                        chk("spurious_apb", 64'(apb_psel), 64'(0));
                        have_cur = 0;
                    end else begin
                        cur = apb_q.pop_front();
                        have_cur = 1;
                        bus_check("setup", cur, 1'b0);
                    end
                end else if (apb_penable != 0) begin
                    if (!have_cur) chk("access_no_setup", 64'(apb_penable), 64'(0));
                    else bus_check("access", cur, 1'b1);
                end
            end
        end
    end

    task automatic bus_check(input string ph, input apb_exp_t e, input logic acc);
        logic [15:0] sel_exp;
        logic ok;
        sel_exp = 16'(1) << e.port;
        ok = (apb_psel == sel_exp) && (apb_penable == (acc ? sel_exp : 16'h0));
        for (int p = 0; p < NP; p++)
            ok = ok && apb_paddr[p] == e.paddr && apb_pwrite[p] == e.pwrite &&
                 apb_pstrb[p] == e.pstrb && apb_pwdata[p] == e.pwdata;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL apb_%s: got psel=%h pen=%h addr=%h wr=%b strb=%h wd=%h expected psel=%h addr=%h wr=%b strb=%h wd=%h",
                     ph, apb_psel, apb_penable, apb_paddr[e.port], apb_pwrite[e.port],
                     apb_pstrb[e.port], apb_pwdata[e.port], sel_exp, e.paddr,
                     e.pwrite, e.pstrb, e.pwdata);
        end
    endtask

    // Host monitor: single-cycle ready pulses carrying queued read data;
    // rdata must hold its last completion value otherwise.
    initial begin : host_mon
        logic [31:0] last = '0;
        logic [31:0] e;
        bit prev = 0;
        forever begin
            @(negedge sys_clk);
            if (rst) begin
                last = '0;
                prev = 0;
            end else begin
                if (host_ready) begin
                    if (prev) chk("ready_width", 64'(1), 64'(0));
                    if (host_q.size() == 0) begin
                        chk("unexpected_ready", 64'(host_ready), 64'(0));
                    end else begin
                        e = host_q.pop_front();
                        chk("host_rdata", 64'(host_rdata), 64'(e));
                        last = e;
                    end
                end else begin
                    chk("rdata_hold", 64'(host_rdata), 64'(last));
                end
                prev = host_ready;
            end
        end
    end

    // Issue one request at a negedge; valid stays high through the
    // DONE->IDLE edge, so a re-issue from DONE shows up as a spurious SETUP.
    task automatic do_req(input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] st, input int wt);
        apb_exp_t e;
        int n = 0;
        bit got = 0;
        wait_cfg   = wt;
        host_addr  = a;
        host_wdata = wd;
        host_wstrb = st;
        host_valid = 1'b1;
        e.port   = int'(a[27:24]);
        e.paddr  = a[23:0];
        e.pwrite = (st != 0);
        e.pstrb  = st;
        e.pwdata = wd;
        apb_q.push_back(e);
        host_q.push_back((st != 0) ? 32'h0 : {tag(e.port), a[23:0]});
        while (n < 40 && !got) begin
            @(negedge sys_clk);
            n++;
            if (n == 1) begin
                host_addr  = $urandom;
                host_wdata = $urandom;
                host_wstrb = 4'($urandom);
            end
            if (host_ready) got = 1;
        end
        chk("latency", 64'(got ? n : -1), 64'(3 + wt));
        @(negedge sys_clk);
        host_valid = 1'b0;
    endtask

    task automatic abort_test;
        apb_exp_t e;
        wait_cfg   = 6;
        host_addr  = 32'h0200_0010;
        host_wdata = 32'h1234_5678;
        host_wstrb = 4'h0;
        host_valid = 1'b1;
        e.port = 2; e.paddr = 24'h000010; e.pwrite = 1'b0;
        e.pstrb = 4'h0; e.pwdata = 32'h1234_5678;
        apb_q.push_back(e);
        repeat (3) @(negedge sys_clk);
        chk("abort_in_access", 64'({apb_psel[2], apb_penable[2]}), 64'(2'b11));
        rst = 1'b1;
        host_valid = 1'b0;
        #1;
        chk("abort_psel", 64'(apb_psel), 64'(0));
        chk("abort_penable", 64'(apb_penable), 64'(0));
        chk("abort_ready", 64'(host_ready), 64'(0));
        repeat (2) @(negedge sys_clk);
        rst = 1'b0;
        repeat (6) @(negedge sys_clk);
        chk("abort_q_empty", 64'(apb_q.size() + host_q.size()), 64'(0));
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  s;
        repeat (3) @(negedge sys_clk);
        chk("rst_ready", 64'(host_ready), 64'(0));
        chk("rst_rdata", 64'(host_rdata), 64'(0));
        chk("rst_psel_pen", 64'({apb_psel, apb_penable}), 64'(0));
        chk("rst_bus", 64'({|apb_paddr, |apb_pwrite, |apb_pstrb, |apb_pwdata}), 64'(0));
        rst = 1'b0;
        @(negedge sys_clk);

        do_req(32'h0012_3456, 32'hAABB_CCDD, 4'hF, 0);
        do_req(32'h0012_3456, 32'h0, 4'h0, 0);
        do_req(32'h01AB_CDEF, 32'h0, 4'h0, 0);
        do_req(32'h0F87_6543, 32'h0, 4'h0, 0);
        for (int i = 0; i < 4; i++) begin
            a = 32'h0123_4567 | (32'(i) << 28);
            do_req(a, 32'hC0DE_0000 + 32'(i), 4'h3, 0);
            do_req(a, 32'h0, 4'h0, 0);
        end
        do_req(32'h0000_0100, 32'h1111_1111, 4'h1, 0);
        do_req(32'h0000_0100, 32'h0, 4'h0, 0);
        do_req(32'h0100_0200, 32'h2222_2222, 4'h8, 0);
        do_req(32'h0100_0200, 32'h0, 4'h0, 0);
        do_req(32'h0FFF_FFFC, 32'h3333_3333, 4'hC, 0);
        do_req(32'h0FFF_FFFC, 32'h0, 4'h0, 0);

        err_cfg = 1'b1;
        do_req(32'h0500_0ABC, 32'h0, 4'h0, 3);
        do_req(32'h0500_0ABC, 32'h5555_AAAA, 4'hF, 3);
        err_cfg = 1'b0;

        for (int i = 0; i < 60; i++) begin
            s = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            err_cfg = 1'($urandom);
            do_req($urandom, $urandom, s, $urandom_range(0, 3));
        end
        err_cfg = 1'b0;

        abort_test();
        do_req(32'h0E00_0042, 32'h0, 4'h0, 1);

        repeat (4) @(negedge sys_clk);
        chk("queues_drained", 64'(apb_q.size() + host_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
